// File: rtl/alu_digit_shifter.sv
// Digit-serial shift/rotate unit: latches an operand, processes one DIGIT-wide slice per clock
// with an internal chain bit, and presents result plus Z/C flags after WIDTH/DIGIT cycles.
module alu_digit_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned SLICES  = WIDTH / DIGIT;
  localparam int unsigned CntW    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned BaseW   = $clog2(WIDTH);
  localparam int unsigned Half    = WIDTH / 2;
  localparam logic [CntW-1:0] CntLast = CntW'(SLICES - 1);

  if ((WIDTH % 2 != 0) || (DIGIT == 0) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("alu_digit_shifter: WIDTH must be even and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [2:0] {OpRlc, OpRrc, OpRl, OpRr, OpSla, OpSra, OpSwap, OpSrl} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             chain_q, chain_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             is_left, is_right;
  logic [CntW-1:0]  idx;
  logic [BaseW-1:0] base;
  logic [WIDTH-1:0] swapped;
  logic [DIGIT-1:0] src, slice;
  logic             chain_nx;

  // Slice datapath: right ops walk high-to-low, everything else low-to-high.
  always_comb begin
    is_left  = op_q inside {OpRlc, OpRl, OpSla};
    is_right = op_q inside {OpRrc, OpRr, OpSra, OpSrl};
    idx      = is_right ? (CntLast - cnt_q) : cnt_q;
    base     = BaseW'(32'(idx) * DIGIT);
    swapped  = {opnd_q[Half-1:0], opnd_q[WIDTH-1:Half]};
    src      = opnd_q[base +: DIGIT];
    slice    = swapped[base +: DIGIT];
    chain_nx = chain_q;
    if (is_left) begin
      slice    = DIGIT'({src, chain_q});
      chain_nx = src[DIGIT-1];
    end else if (is_right) begin
      slice    = DIGIT'({chain_q, src} >> 1);
      chain_nx = src[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_e'(op);
          opnd_d  = operand;
          cnt_d   = '0;
          state_d = StRun;
          unique case (op_e'(op))
            OpRlc, OpSra:       chain_d = operand[WIDTH-1];
            OpRrc:              chain_d = operand[0];
            OpRl, OpRr:         chain_d = cin;
            OpSla, OpSrl, OpSwap: chain_d = 1'b0;
          endcase
        end
      end
      StRun: begin
        acc_d[base +: DIGIT] = slice;
        chain_d = chain_nx;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          cnt_d    = '0;
          result_d = acc_d;
          zero_d   = (acc_d == '0);
          unique case (op_q)
            OpRlc, OpRl, OpSla: carry_d = opnd_q[WIDTH-1];
            OpSwap:             carry_d = 1'b0;
            default:            carry_d = opnd_q[0];
          endcase
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= StIdle;
      op_q     <= OpRlc;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      chain_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_digit_shifter.sv
// Directed bench for alu_digit_shifter: three instances (8/4, 16/4, 8/8) with hand-computed
// results, busy-cycle counts, start-while-busy and mid-operation reset.
module tb_alu_digit_shifter;

  logic        clk = 1'b0;
  logic        nreset;
  logic [2:0]  opc;
  logic [15:0] opnd;
  logic        cin;
  logic        start_a, start_b, start_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        zero_a, zero_b, zero_c, carry_a, carry_b, carry_c;
  logic [7:0]  result_a, result_c;
  logic [15:0] result_b;

  int          sel;
  logic        bsy, dn, zr, cy;
  logic [15:0] res;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  alu_digit_shifter #(.WIDTH(8), .DIGIT(4)) u_a (
    .clk(clk), .nreset(nreset), .start(start_a), .op(opc), .operand(opnd[7:0]), .cin(cin),
    .busy(busy_a), .done(done_a), .result(result_a), .zero(zero_a), .carry(carry_a)
  );

  alu_digit_shifter #(.WIDTH(16), .DIGIT(4)) u_b (
    .clk(clk), .nreset(nreset), .start(start_b), .op(opc), .operand(opnd), .cin(cin),
    .busy(busy_b), .done(done_b), .result(result_b), .zero(zero_b), .carry(carry_b)
  );

  alu_digit_shifter #(.WIDTH(8), .DIGIT(8)) u_c (
    .clk(clk), .nreset(nreset), .start(start_c), .op(opc), .operand(opnd[7:0]), .cin(cin),
    .busy(busy_c), .done(done_c), .result(result_c), .zero(zero_c), .carry(carry_c)
  );

  always_comb begin
    bsy = busy_a;
    dn  = done_a;
    res = {8'h00, result_a};
    zr  = zero_a;
    cy  = carry_a;
    if (sel == 1) begin
      bsy = busy_b; dn = done_b; res = result_b; zr = zero_b; cy = carry_b;
    end else if (sel == 2) begin
      bsy = busy_c; dn = done_c; res = {8'h00, result_c}; zr = zero_c; cy = carry_c;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation on instance s; called half a cycle away from the clock edge.
  task automatic go(input int s, input logic [2:0] o, input logic [15:0] v, input logic ci,
                    input logic [15:0] er, input logic ec, input logic ez, input int ns,
                    input string tag);
    logic [15:0] prev;
    int n;
    sel  = s;
    prev = (s == 1) ? result_b : (s == 2) ? {8'h00, result_c} : {8'h00, result_a};
    opc  = o;
    opnd = v;
    cin  = ci;
    start_a = (s == 0);
    start_b = (s == 1);
    start_c = (s == 2);
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    chk({tag, ":held_at_accept"}, res, prev);
    n = 0;
    while (bsy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, ":busy_cycles"}, n, ns);
    chk({tag, ":done"}, dn, 1);
    chk({tag, ":result"}, res, er);
    chk({tag, ":carry"}, cy, ec);
    chk({tag, ":zero"}, zr, ez);
    @(posedge clk); #1;
    chk({tag, ":done_drop"}, {bsy, dn}, 2'b00);
    chk({tag, ":result_kept"}, res, er);
  endtask

  initial begin
    int pulses, both;
    nreset = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    opc = 3'd0; opnd = 16'h0000; cin = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {busy_a, done_a, zero_a, carry_a, result_a}, 0);
    chk("rst_b", {busy_b, done_b, zero_b, carry_b, result_b}, 0);
    chk("rst_c", {busy_c, done_c, zero_c, carry_c, result_c}, 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    go(0, 3'd1, 16'h0001, 1'b0, 16'h0080, 1'b1, 1'b0, 2, "a_rrc_01");
    go(0, 3'd2, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 2, "a_rl_80_c0");
    go(0, 3'd2, 16'h0080, 1'b1, 16'h0001, 1'b1, 1'b0, 2, "a_rl_80_c1");
    go(0, 3'd5, 16'h0081, 1'b0, 16'h00C0, 1'b1, 1'b0, 2, "a_sra_81");
    go(0, 3'd6, 16'h00A5, 1'b1, 16'h005A, 1'b0, 1'b0, 2, "a_swap_a5");
    go(0, 3'd7, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 2, "a_srl_01");
    go(0, 3'd0, 16'h0081, 1'b0, 16'h0003, 1'b1, 1'b0, 2, "a_rlc_81");
    go(0, 3'd4, 16'h00C3, 1'b0, 16'h0086, 1'b1, 1'b0, 2, "a_sla_c3");
    go(0, 3'd3, 16'h0002, 1'b1, 16'h0081, 1'b0, 1'b0, 2, "a_rr_02_c1");

    go(1, 3'd3, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 4, "b_rr_0001_c1");
    go(1, 3'd6, 16'h1234, 1'b0, 16'h3412, 1'b0, 1'b0, 4, "b_swap_1234");
    go(2, 3'd0, 16'h0081, 1'b0, 16'h0003, 1'b1, 1'b0, 1, "c_rlc_81");
    go(2, 3'd6, 16'h00A5, 1'b0, 16'h005A, 1'b0, 1'b0, 1, "c_swap_a5");

    // Second start while busy must be dropped.
    sel = 0; opc = 3'd1; opnd = 16'h0001; cin = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    opc = 3'd6; opnd = 16'h00A5;
    @(posedge clk); #1;
    start_a = 1'b0;
    pulses = 0; both = 0;
    repeat (8) begin
      if (dn) pulses++;
      if (bsy && dn) both++;
      @(posedge clk); #1;
    end
    chk("dbl_start:pulses", pulses, 1);
    chk("dbl_start:busy_and_done", both, 0);
    chk("dbl_start:result", res, 16'h0080);
    chk("dbl_start:carry", cy, 1);

    // Reset in the cycle after acceptance discards the operation.
    opc = 3'd7; opnd = 16'h0080; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    nreset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst:busy_done", {bsy, dn}, 2'b00);
    chk("mid_rst:result", res, 16'h0000);
    chk("mid_rst:flags", {zr, cy}, 2'b00);
    nreset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (dn || bsy) pulses++;
    end
    chk("mid_rst:no_activity", pulses, 0);
    chk("mid_rst:result_stays", res, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_digit_shifter.md
# alu_digit_shifter

Parametrised digit-serial shift/rotate unit for the ALU datapath, generalising the nibble-wide two-pass rotate to any operand width and slice width. It latches a full operand and processes one DIGIT-wide slice per clock, carrying the inter-slice bit internally. After WIDTH/DIGIT cycles it presents the result and Z/C flags. It sits beside the adder slice and serves the CB-prefix shift/rotate group plus wider internal shifts.

## Interface
- WIDTH, 8: operand width in bits.
  - Must be even and a multiple of DIGIT.
- DIGIT, 4: slice width processed per cycle.
  - SLICES = WIDTH/DIGIT, with SLICES >= 1.
- clk  in  1  clock; all state updates on rising edge.
- nreset  in  1  synchronous, active-low reset; one clock; sampled on rising edge of clk.
- start  in  1  request; sampled only while idle.
- op  in  3  operation code, latched with start:
  - 0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL.
- operand  in  WIDTH  value to shift; latched with start.
- cin  in  1  carry flag input for RL/RR; latched with start.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse when result and flags become valid.
- result  out  WIDTH  shifted value; held until the next accepted start.
- zero  out  1  result == 0; held with result.
- carry  out  1  bit shifted out; held with result.

## Operation
- States: IDLE, RUN, DONE. Slice counter cnt counts 0..SLICES-1.
- IDLE:
  - start=1 latches op, operand and cin, clears cnt, and loads the chain bit.
  - Next state is RUN.
  - result, zero and carry are not modified at acceptance.
- RUN: each cycle computes one DIGIT-wide result slice and increments cnt.
  - Left ops (RLC, RL, SLA) process slices from low to high.
  - Right ops (RRC, RR, SRA, SRL) process slices from high to low.
  - SWAP processes slices from low to high.
- Chain bit: the bit entering the current slice's vacated end.
  - It is updated each cycle to the bit leaving that slice, so no full-width shifter is needed.
- Initial chain bit by op:
  - RLC: operand[WIDTH-1].
  - RRC: operand[0].
  - RL, RR: cin.
  - SLA, SRL: 0.
  - SRA: operand[WIDTH-1].
- SWAP: result = {operand[WIDTH/2-1:0], operand[WIDTH-1:WIDTH/2]}, written one slice per cycle.
- After cnt reaches SLICES-1, the FSM moves to DONE.
- DONE lasts one cycle:
  - done=1.
  - result holds the full value.
  - zero = (result == 0).
  - carry:
    - operand[WIDTH-1] for RLC, RL, SLA.
    - operand[0] for RRC, RR, SRA, SRL.
    - 0 for SWAP.
  - Next state is IDLE.
  - start during DONE is ignored.
- result, zero and carry update only on the DONE transition. Partial slices live in an internal accumulator, so outputs never expose half-written values.
- start while busy or done is ignored; no queueing.
- Reset (nreset=0 at a rising edge), including mid-operation:
  - Next state is IDLE, cnt=0.
  - busy=0, done=0, result=0, zero=0, carry=0.
  - The in-flight operation is discarded.
- Reset has priority over start in the same cycle.

## Timing
- start accepted at edge E0 → busy=1 for cycles E0..E(SLICES-1).
- At edge E(SLICES): busy=0, done=1, result/zero/carry valid.
- Latency from start to done is SLICES+1 cycles. With WIDTH=8, DIGIT=4, done is high in the 3rd cycle after the start cycle.
- A new start is accepted on the cycle after done falls. Throughput is one op per SLICES+2 cycles.
- done is never high in two consecutive cycles.
- busy and done are never high together.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=4, RRC, operand 0x01 → result 0x80, carry=1, zero=0.
  - busy high for 2 cycles, done in the 3rd cycle after start.
- RL, operand 0x80, cin=0 → result 0x00, carry=1, zero=1.
- RL, operand 0x80, cin=1 → result 0x01, carry=1, zero=0.
- SRA, operand 0x81 → result 0xC0, carry=1.
- SWAP, operand 0xA5 → result 0x5A, carry=0.
- SRL, operand 0x01 → result 0x00, zero=1, carry=1.
- Second start one cycle after the first → ignored: exactly one done pulse, first result retained.
- nreset=0 in the cycle after start → busy=0, done=0, result=0; no done pulse follows.
- WIDTH=16, DIGIT=4, RR, operand 0x0001, cin=1 → result 0x8000, carry=1.
  - busy high for 4 cycles.
- WIDTH=8, DIGIT=8 (SLICES=1), RLC, operand 0x81 → result 0x03, carry=1, done in the 2nd cycle after start.
